picorv32_axi_mem: RTL and testbench
===================================

# picorv32_axi_mem

AXI4-lite slave memory that sits directly downstream of the PicoRV32 AXI master adapter and terminates its AW/W/B and AR/R channels. It stores MEM_WORDS 32-bit words behind a single-outstanding-transaction state machine. It supports byte-strobed writes, a programmable read latency and SLVERR responses for out-of-range addresses. It is the standard memory model for core and SoC benches and the on-chip RAM for small systems.

## Interface

- MEM_WORDS, 1024: memory depth in 32-bit words (power of two, ≥ 4).
- ADDR_BASE, 32'h0000_0000: byte address of word 0; aligned to MEM_WORDS*4.
- LATENCY, 1: extra read wait cycles, 0..15.

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_axi_awvalid / awready  in / out  1 / 1  write-address handshake.
- mem_axi_awaddr  in  32  write byte address; bits [1:0] ignored.
- mem_axi_awprot  in  3  accepted, ignored.
- mem_axi_wvalid / wready  in / out  1 / 1  write-data handshake.
- mem_axi_wdata  in  32  write data.
- mem_axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- mem_axi_bvalid / bready  out / in  1 / 1  write response.
- mem_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- mem_axi_arvalid / arready  in / out  1 / 1  read-address handshake.
- mem_axi_araddr  in  32  read byte address; bits [1:0] ignored.
- mem_axi_arprot  in  3  accepted, ignored.
- mem_axi_rvalid / rready  out / in  1 / 1  read response.
- mem_axi_rdata  out  32  read data.
- mem_axi_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.

## Operation

- States: IDLE, WCOLLECT, WRESP, RWAIT, RRESP. One transaction is in flight at a time.
- IDLE: awready=wready=arready=1.
  - If awvalid or wvalid is high, accept whichever is valid and do not accept AR in that cycle. Writes win a simultaneous AW/W/AR.
  - If only one of AW/W is accepted, go to WCOLLECT. If both are accepted, go to WRESP.
  - If only arvalid is high, accept AR, load the latency counter with LATENCY, and go to RWAIT.
- WCOLLECT: the ready of the already-captured channel is 0 and the other channel's ready is 1. On the missing handshake, go to WRESP.
- Memory write: occurs on the edge where the second of AW/W completes, using the captured or live address, data and strobes.
  - Only bytes with wstrb=1 change. wstrb=0 is a legal no-op that is still responded OKAY.
- In range: ADDR_BASE ≤ addr < ADDR_BASE+MEM_WORDS*4. Word index = (addr−ADDR_BASE)>>2.
- Out-of-range write: memory is unchanged and bresp=SLVERR.
- WRESP: bvalid=1 and bresp is held until bready; on the handshake, go to IDLE.
- RWAIT: decrement the counter each cycle. At 0, register rdata/rresp from memory and go to RRESP.
- Out-of-range read: rdata=0, rresp=SLVERR.
- RRESP: rvalid=1; rdata and rresp are stable until rready; on the handshake, go to IDLE.
- Readies are 0 in WRESP, RWAIT and RRESP.
- Reset values: all readies and valids 0, bresp=rresp=0, rdata=0, state IDLE, counter 0. Memory contents are not reset.
- Reset asserted mid-transaction aborts it. A pending response is dropped. A write is either fully done or not done; no partial bytes are written.

## Timing

- Ready outputs decode from registered state only; they never depend combinationally on valids.
- Write: AW and W both handshake at edge N → bvalid from cycle N+1. If they are split, N is the later edge.
- Read: AR handshake at edge N → rvalid from cycle N+1+LATENCY. LATENCY=0 gives rvalid in cycle N+1.
- Response handshake at edge M → readies are high again in cycle M+1.
- Minimum period: 2 cycles per write; 2+LATENCY cycles per read (zero-wait responder).

## Configuration

- PICORV32_AXI_MEM_STALL_EN defined: adds a 16-bit LFSR.
  - Polynomial x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advances every cycle.
  - In any cycle with lfsr[0]=1, awready, wready and arready are forced to 0. State transitions honour the gated readies.
  - Used to stress the master's valid-hold behaviour.
- Undefined: no LFSR, and readies behave exactly as described above.

## Test plan

- Write 32'hDEADBEEF to 0x10 (AW and W in the same cycle, wstrb=4'hF), then read 0x10 with LATENCY=1 → bvalid 1 cycle after AW/W, bresp=0; rvalid 2 cycles after AR, rdata=32'hDEADBEEF, rresp=0.
- AW to 0x20 at cycle 0, W (32'h11223344) at cycle 3; then wstrb=4'b0010 with wdata=32'h0000AA00 → bvalid at cycle 4; a later read returns 32'h1122AA44.
- Write and read at ADDR_BASE+MEM_WORDS*4 → bresp=2'b10 and memory unchanged; rresp=2'b10 and rdata=0.
- AW, W and AR all valid in the same IDLE cycle → write completes first; AR is accepted only after the B handshake and returns the newly written data.
- Hold rready=0 for 5 cycles during RRESP, then assert reset for 1 cycle during RWAIT of a second read → rdata stable throughout the hold; after reset rvalid=0, state IDLE, readies=1 in the cycle after reset deasserts.
- With PICORV32_AXI_MEM_STALL_EN, run 1000 random read/write transactions against a scoreboard → no data mismatch, and every valid is held until its handshake.

Source files
------------

// File: rtl/picorv32_axi_mem.sv
// picorv32_axi_mem: AXI4-lite slave RAM, one transaction in flight at a time.
// Optional ready stalling via a 16-bit LFSR: define PICORV32_AXI_MEM_STALL_EN.
module picorv32_axi_mem #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  output logic [1:0]  mem_axi_bresp,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic [1:0]  mem_axi_rresp
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  LAT  = 4'(LATENCY);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WCOLLECT, WRESP, RWAIT, RRESP
  } state_t;

  state_t state, state_nx;

  logic [31:0] mem [MEM_WORDS];

  logic        aw_got, w_got;
  logic [31:0] aw_q, w_q, ar_q;
  logic [3:0]  strb_q;
  logic [3:0]  cnt;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic        stall;
  logic        aw_hs, w_hs, ar_hs;
  logic        wr_fire, rd_cap;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_strb;
  logic [31:0] wr_off, rd_off;
  logic        wr_ok, rd_ok;
  logic [AW-1:0] wr_idx, rd_idx;

  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, ADDR_BASE};
    return !off[32] && (off < SPAN);
  endfunction

`ifdef PICORV32_AXI_MEM_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advances every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // Handshakes; AR only wins IDLE when no write channel is valid
  assign aw_hs = mem_axi_awvalid & mem_axi_awready;
  assign w_hs  = mem_axi_wvalid & mem_axi_wready;
  assign ar_hs = mem_axi_arvalid & mem_axi_arready
               & ~mem_axi_awvalid & ~mem_axi_wvalid;

  // Write commits on the edge where the second of AW/W lands
  assign wr_fire = (aw_got | aw_hs) & (w_got | w_hs) & (aw_hs | w_hs);
  assign wr_addr = aw_got ? aw_q : mem_axi_awaddr;
  assign wr_data = w_got ? w_q : mem_axi_wdata;
  assign wr_strb = w_got ? strb_q : mem_axi_wstrb;
  assign wr_off  = wr_addr - ADDR_BASE;
  assign wr_idx  = wr_off[AW+1:2];
  assign wr_ok   = in_range(wr_addr);

  // Zero-latency reads sample the live address straight from IDLE
  assign rd_addr = (state == IDLE) ? mem_axi_araddr : ar_q;
  assign rd_off  = rd_addr - ADDR_BASE;
  assign rd_idx  = rd_off[AW+1:2];
  assign rd_ok   = in_range(rd_addr);
  assign rd_cap  = (ar_hs && LAT == 4'd0)
                 || (state == RWAIT && cnt == 4'd1);

  logic unused;
  assign unused = ^{mem_axi_awprot, mem_axi_arprot, wr_off, rd_off};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (aw_hs && w_hs) state_nx = WRESP;
        else if (aw_hs || w_hs) state_nx = WCOLLECT;
        else if (ar_hs) state_nx = (LAT == 4'd0) ? RRESP : RWAIT;
      end
      WCOLLECT: if (wr_fire) state_nx = WRESP;
      WRESP:    if (mem_axi_bready) state_nx = IDLE;
      RWAIT:    if (cnt == 4'd1) state_nx = RRESP;
      RRESP:    if (mem_axi_rready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    mem_axi_awready = 1'b0;
    mem_axi_wready  = 1'b0;
    mem_axi_arready = 1'b0;
    unique case (state)
      IDLE: begin
        mem_axi_awready = 1'b1;
        mem_axi_wready  = 1'b1;
        mem_axi_arready = 1'b1;
      end
      WCOLLECT: begin
        mem_axi_awready = ~aw_got;
        mem_axi_wready  = ~w_got;
      end
      default: ;
    endcase
    if (reset || stall) begin
      mem_axi_awready = 1'b0;
      mem_axi_wready  = 1'b0;
      mem_axi_arready = 1'b0;
    end
    mem_axi_bvalid = (state == WRESP);
    mem_axi_rvalid = (state == RRESP);
    mem_axi_bresp  = bresp_q;
    mem_axi_rresp  = rresp_q;
    mem_axi_rdata  = rdata_q;
  end

  // Channel capture, latency counter and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_q    <= '0;
      w_q     <= '0;
      strb_q  <= '0;
      ar_q    <= '0;
      cnt     <= '0;
      bresp_q <= OKAY;
      rresp_q <= OKAY;
      rdata_q <= '0;
    end else begin
      if (aw_hs && !wr_fire) begin
        aw_got <= 1'b1;
        aw_q   <= mem_axi_awaddr;
      end
      if (w_hs && !wr_fire) begin
        w_got  <= 1'b1;
        w_q    <= mem_axi_wdata;
        strb_q <= mem_axi_wstrb;
      end
      if (wr_fire) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        bresp_q <= wr_ok ? OKAY : SLVERR;
      end
      if (ar_hs) begin
        ar_q <= mem_axi_araddr;
        cnt  <= LAT;
      end else if (state == RWAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_cap) begin
        rdata_q <= rd_ok ? mem[rd_idx] : 32'h0;
        rresp_q <= rd_ok ? OKAY : SLVERR;
      end
    end
  end

  // Byte-strobed memory write; never while reset is asserted
  always_ff @(posedge clk) begin
    if (wr_fire && wr_ok && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_picorv32_axi_mem.sv
// tb_picorv32_axi_mem: directed and randomized checks of picorv32_axi_mem
// against a word-array reference model.
module tb_picorv32_axi_mem;

  localparam int          WORDS = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          LAT   = 1;
  localparam logic [31:0] TOP   = BASE + WORDS * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [2:0]  awprot, arprot;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [WORDS];

  picorv32_axi_mem #(
    .MEM_WORDS(WORDS),
    .ADDR_BASE(BASE),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_axi_awvalid(awvalid),
    .mem_axi_awready(awready),
    .mem_axi_awaddr(awaddr),
    .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid),
    .mem_axi_wready(wready),
    .mem_axi_wdata(wdata),
    .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid),
    .mem_axi_bready(bready),
    .mem_axi_bresp(bresp),
    .mem_axi_arvalid(arvalid),
    .mem_axi_arready(arready),
    .mem_axi_araddr(araddr),
    .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid),
    .mem_axi_rready(rready),
    .mem_axi_rdata(rdata),
    .mem_axi_rresp(rresp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a >= BASE && a < TOP;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [31:0] d,
                                      input logic [3:0] s);
    if (!in_rng(a)) return;
    for (int b = 0; b < 4; b++)
      if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return in_rng(a) ? model[widx(a)] : 32'h0;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int aw_dly, input int w_dly,
                    output logic [1:0] resp, output int lat);
    bit awd, wd, af, wf;
    int cyc;
    awd = 0; wd = 0; cyc = 0;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b0;
    while (!(awd && wd) && cyc < 200) begin
      awvalid = !awd && cyc >= aw_dly;
      wvalid  = !wd && cyc >= w_dly;
      af = awvalid && awready;
      wf = wvalid && wready;
      tick();
      if (af) awd = 1;
      if (wf) wd = 1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("wr_handshake_timeout", 32'(awd && wd), 32'd1);
    cyc = 1;
    while (!bvalid && cyc < 50) begin
      tick();
      cyc++;
    end
    lat = bvalid ? cyc : -1;
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input int hold,
                    output logic [31:0] data, output logic [1:0] resp,
                    output int lat);
    bit arf;
    int cyc;
    arf = 0; cyc = 0;
    araddr = a; rready = 1'b0;
    while (!arf && cyc < 200) begin
      arvalid = 1'b1;
      arf = arready;
      tick();
      cyc++;
    end
    arvalid = 1'b0;
    chk("rd_handshake_timeout", 32'(arf), 32'd1);
    cyc = 1;
    while (!rvalid && cyc < 50) begin
      tick();
      cyc++;
    end
    lat = rvalid ? cyc : -1;
    data = rdata;
    resp = rresp;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("rd_hold_rvalid", 32'(rvalid), 32'd1);
      chk("rd_hold_rdata", rdata, data);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data, a, d;
    logic [3:0]  s;
    int          lat, cyc;
    bit          af, wf, arf, early;

    reset = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    awprot = 3'd0; arprot = 3'd0;
    tick();
    tick();
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
    tick();
`ifndef PICORV32_AXI_MEM_STALL_EN
    chk("idle_awready", 32'(awready), 1);
    chk("idle_wready", 32'(wready), 1);
    chk("idle_arready", 32'(arready), 1);
`endif

    for (int i = 0; i < WORDS; i++) begin
      d = $urandom;
      wr(BASE + 32'(i * 4), d, 4'hF, 0, 0, resp, lat);
      model_write(BASE + 32'(i * 4), d, 4'hF);
      chk("init_bresp", 32'(resp), 0);
    end

    wr(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat);
    model_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF);
    chk("t1_bresp", 32'(resp), 0);
    chk("t1_blat", 32'(lat), 1);
    rd(BASE + 32'h10, 0, data, resp, lat);
    chk("t1_rdata", data, 32'hDEADBEEF);
    chk("t1_rresp", 32'(resp), 0);
    chk("t1_rlat", 32'(lat), 32'(1 + LAT));

    wr(BASE + 32'h20, 32'h11223344, 4'hF, 0, 3, resp, lat);
    model_write(BASE + 32'h20, 32'h11223344, 4'hF);
    chk("t2_split_blat", 32'(lat), 1);
    chk("t2_split_bresp", 32'(resp), 0);
    wr(BASE + 32'h20, 32'h0000AA00, 4'b0010, 2, 0, resp, lat);
    model_write(BASE + 32'h20, 32'h0000AA00, 4'b0010);
    chk("t2_strb_blat", 32'(lat), 1);
    rd(BASE + 32'h20, 0, data, resp, lat);
    chk("t2_strb_rdata", data, 32'h1122AA44);

    wr(BASE + 32'h24, 32'hFFFFFFFF, 4'h0, 0, 0, resp, lat);
    chk("t2_nostrb_bresp", 32'(resp), 0);
    rd(BASE + 32'h24, 0, data, resp, lat);
    chk("t2_nostrb_rdata", data, model_rdata(BASE + 32'h24));

    wr(TOP, 32'h55555555, 4'hF, 0, 0, resp, lat);
    chk("t3_oor_bresp", 32'(resp), 32'd2);
    wr(BASE - 32'd4, 32'h66666666, 4'hF, 0, 0, resp, lat);
    chk("t3_below_bresp", 32'(resp), 32'd2);
    rd(BASE, 0, data, resp, lat);
    chk("t3_alias_unchanged", data, model_rdata(BASE));
    rd(BASE + 32'hFC, 0, data, resp, lat);
    chk("t3_last_unchanged", data, model_rdata(BASE + 32'hFC));
    rd(TOP, 0, data, resp, lat);
    chk("t3_oor_rresp", 32'(resp), 32'd2);
    chk("t3_oor_rdata", data, 32'h0);

    d = 32'hC0FFEE01;
    awaddr = BASE + 32'h14; wdata = d; wstrb = 4'hF;
    araddr = BASE + 32'h14;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 0;
    af = 0; wf = 0; early = 0; cyc = 0;
    while (!bvalid && cyc < 100) begin
      if (awvalid && awready) af = 1;
      if (wvalid && wready) wf = 1;
      tick();
      if (af) awvalid = 0;
      if (wf) wvalid = 0;
      if (rvalid) early = 1;
      cyc++;
    end
    model_write(BASE + 32'h14, d, 4'hF);
    chk("t4_bvalid_seen", 32'(bvalid), 1);
    chk("t4_bresp", 32'(bresp), 0);
    chk("t4_no_early_read", 32'(early || rvalid), 0);
    tick();
    bready = 0;
    arf = 0; cyc = 0;
    while (!arf && cyc < 100) begin
      arf = arready;
      tick();
      cyc++;
    end
    arvalid = 0;
    cyc = 1;
    while (!rvalid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("t4_rlat", 32'(cyc), 32'(1 + LAT));
    chk("t4_rdata_new", rdata, d);
    rready = 1;
    tick();
    rready = 0;

    rd(BASE + 32'h10, 5, data, resp, lat);
    chk("t5_hold_rdata", data, 32'hDEADBEEF);
    araddr = BASE + 32'h10;
    arvalid = 1;
    arf = 0; cyc = 0;
    while (!arf && cyc < 100) begin
      arf = arready;
      tick();
      cyc++;
    end
    arvalid = 0;
    chk("t5_rwait_rvalid", 32'(rvalid), 0);
    reset = 1;
    #1;
    chk("t5_rst_rvalid", 32'(rvalid), 0);
    chk("t5_rst_arready", 32'(arready), 0);
    tick();
    reset = 0;
    tick();
    chk("t5_after_rvalid", 32'(rvalid), 0);
`ifndef PICORV32_AXI_MEM_STALL_EN
    chk("t5_after_awready", 32'(awready), 1);
    chk("t5_after_wready", 32'(wready), 1);
    chk("t5_after_arready", 32'(arready), 1);
`endif
    tick();
    tick();
    chk("t5_dropped_rvalid", 32'(rvalid), 0);
    rd(BASE + 32'h10, 0, data, resp, lat);
    chk("t5_mem_kept", data, 32'hDEADBEEF);

    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 9))
        0: a = TOP + 32'($urandom_range(0, 15) * 4);
        1: a = BASE - 32'($urandom_range(1, 16) * 4);
        default: a = BASE + 32'($urandom_range(0, WORDS * 4 - 1));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        wr(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), resp, lat);
        model_write(a, d, s);
        chk("rnd_bresp", 32'(resp), in_rng(a) ? 32'd0 : 32'd2);
        chk("rnd_blat", 32'(lat), 1);
      end else begin
        rd(a, $urandom_range(0, 2), data, resp, lat);
        chk("rnd_rdata", data, model_rdata(a));
        chk("rnd_rresp", 32'(resp), in_rng(a) ? 32'd0 : 32'd2);
        chk("rnd_rlat", 32'(lat), 32'(1 + LAT));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
